// File: rtl/keypad_scan.sv
// 4x4 matrix keypad scanner: walks an active-low column drive, debounces the
// first low row seen, and reports the accepted key until it is released.
module keypad_scan #(
  parameter int DIV  = 4999,
  parameter int DB_N = 7
) (
  input  logic       MHz,
  input  logic       Reset,
  input  logic [3:0] row,
  output logic [3:0] col,
  output logic [3:0] key,
  output logic       valid,
  output logic       pressed
);

  localparam int              CW     = (DIV > 0) ? $clog2(DIV + 1) : 1;
  localparam int              DW     = (DB_N > 0) ? $clog2(DB_N + 1) : 1;
  localparam logic [CW-1:0]   DIV_V  = CW'(DIV);
  localparam logic [DW-1:0]   DB_MAX = DW'(DB_N);

  typedef enum logic [1:0] {
    SCAN,
    PDB,
    HELD,
    RDB
  } state_t;

  state_t        state;
  logic [3:0]    r1;
  logic [3:0]    rs;
  logic [CW-1:0] cnt;
  logic          tick;
  logic [1:0]    col_idx;
  logic [1:0]    r_idx;
  logic [DW-1:0] db_cnt;
  logic [DW-1:0] db_inc;
  logic [1:0]    low_idx;
  logic          low_found;
  logic          sel_high;

  always_ff @(posedge MHz or negedge Reset) begin
    if (!Reset) begin
      r1 <= '1;
      rs <= '1;
    end else begin
      r1 <= row;
      rs <= r1;
    end
  end

  always_ff @(posedge MHz or negedge Reset) begin
    if (!Reset)    cnt <= '0;
    else if (tick) cnt <= '0;
    else           cnt <= cnt + CW'(1);
  end

  assign tick = (cnt == DIV_V);

  // Lowest-numbered low row wins when several rows are low together.
  always_comb begin
    low_idx   = '0;
    low_found = 1'b0;
    for (int unsigned i = 0; i < 4; i++) begin
      if (!rs[i] && !low_found) begin
        low_idx   = 2'(i);
        low_found = 1'b1;
      end
    end
  end

  assign sel_high = rs[r_idx];
  assign db_inc   = (db_cnt == DB_MAX) ? db_cnt : db_cnt + DW'(1);
  assign col      = ~(4'b0001 << col_idx);

  always_ff @(posedge MHz or negedge Reset) begin
    if (!Reset) begin
      state   <= SCAN;
      col_idx <= '0;
      r_idx   <= '0;
      db_cnt  <= '0;
      key     <= '0;
      valid   <= 1'b0;
      pressed <= 1'b0;
    end else begin
      valid <= 1'b0;
      if (tick) begin
        case (state)
          SCAN: begin
            if (rs == 4'hF) begin
              col_idx <= col_idx + 2'd1;
            end else begin
              r_idx  <= low_idx;
              db_cnt <= '0;
              state  <= PDB;
            end
          end
          PDB: begin
            if (!sel_high) begin
              db_cnt <= db_inc;
              if (db_inc == DB_MAX) begin
                key     <= {r_idx, col_idx};
                valid   <= 1'b1;
                pressed <= 1'b1;
                state   <= HELD;
              end
            end else begin
              col_idx <= col_idx + 2'd1;
              state   <= SCAN;
            end
          end
          HELD: begin
            if (sel_high) begin
              db_cnt <= DW'(1);
              state  <= RDB;
            end
          end
          RDB: begin
            if (sel_high) begin
              db_cnt <= db_inc;
              if (db_inc == DB_MAX) begin
                pressed <= 1'b0;
                col_idx <= col_idx + 2'd1;
                state   <= SCAN;
              end
            end else begin
              state <= HELD;
            end
          end
          default: state <= SCAN;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_keypad_scan.sv
// Bench for keypad_scan with DIV=3, DB_N=3: directed tick table, reset corner
// cases, then random row activity checked against a tick-level reference model.
module tb_keypad_scan;

  localparam int DBN = 3;

  logic       MHz;
  logic       Reset;
  logic [3:0] row;
  logic [3:0] col;
  logic [3:0] key;
  logic       valid;
  logic       pressed;

  keypad_scan #(.DIV(3), .DB_N(3)) dut (
    .MHz    (MHz),
    .Reset  (Reset),
    .row    (row),
    .col    (col),
    .key    (key),
    .valid  (valid),
    .pressed(pressed)
  );

  initial MHz = 1'b0;
  always #5 MHz = ~MHz;

  int n_chk  = 0;
  int n_fail = 0;

  typedef struct {
    logic [3:0] row;
    logic [3:0] col;
    logic [3:0] key;
    logic       valid;
    logic       pressed;
  } vec_t;

  vec_t vecs[31];

  // Reference model state, one step per scan tick.
  int         m_col;
  bit         m_lock;
  bit         m_held;
  int         m_row;
  int         m_run;
  logic [3:0] m_key;
  logic       m_valid;

  task automatic chk(input string name, input logic [3:0] act, input logic [3:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Row is applied just after a tick edge and held for a full tick period.
  task automatic apply_tick(input logic [3:0] r);
    row = r;
    for (int unsigned e = 0; e < 3; e++) begin
      @(posedge MHz); #1;
      chk("valid_between_ticks", {3'b0, valid}, 4'h0);
    end
    @(posedge MHz); #1;
  endtask

  task automatic model_reset();
    m_col   = 0;
    m_lock  = 0;
    m_held  = 0;
    m_row   = 0;
    m_run   = 0;
    m_key   = 4'h0;
    m_valid = 1'b0;
  endtask

  task automatic model_step(input logic [3:0] r);
    m_valid = 1'b0;
    if (!m_lock) begin
      if (r == 4'hF) m_col = (m_col + 1) % 4;
      else begin
        for (int i = 3; i >= 0; i--) if (!r[i]) m_row = i;
        m_lock = 1;
        m_held = 0;
        m_run  = 0;
      end
    end else if (!m_held) begin
      if (!r[m_row]) begin
        m_run++;
        if (m_run == DBN) begin
          m_held  = 1;
          m_run   = 0;
          m_key   = 4'(m_row * 4 + m_col);
          m_valid = 1'b1;
        end
      end else begin
        m_lock = 0;
        m_col  = (m_col + 1) % 4;
      end
    end else begin
      if (r[m_row]) begin
        m_run++;
        if (m_run == DBN) begin
          m_held = 0;
          m_lock = 0;
          m_col  = (m_col + 1) % 4;
        end
      end else m_run = 0;
    end
  endtask

  task automatic model_check();
    logic [3:0] ec;
    ec = 4'hF;
    ec[m_col] = 1'b0;
    chk("rand_col", col, ec);
    chk("rand_key", key, m_key);
    chk("rand_valid", {3'b0, valid}, {3'b0, m_valid});
    chk("rand_pressed", {3'b0, pressed}, {3'b0, m_held});
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [3:0] r;
    int         ticks;
    int         len;

    vecs[0]  = '{4'hF, 4'hD, 4'h0, 1'b0, 1'b0};
    vecs[1]  = '{4'hF, 4'hB, 4'h0, 1'b0, 1'b0};
    vecs[2]  = '{4'hF, 4'h7, 4'h0, 1'b0, 1'b0};
    vecs[3]  = '{4'hF, 4'hE, 4'h0, 1'b0, 1'b0};
    vecs[4]  = '{4'hF, 4'hD, 4'h0, 1'b0, 1'b0};
    vecs[5]  = '{4'hB, 4'hD, 4'h0, 1'b0, 1'b0};
    vecs[6]  = '{4'hB, 4'hD, 4'h0, 1'b0, 1'b0};
    vecs[7]  = '{4'hB, 4'hD, 4'h0, 1'b0, 1'b0};
    vecs[8]  = '{4'hB, 4'hD, 4'h9, 1'b1, 1'b1};
    vecs[9]  = '{4'hB, 4'hD, 4'h9, 1'b0, 1'b1};
    vecs[10] = '{4'hF, 4'hD, 4'h9, 1'b0, 1'b1};
    vecs[11] = '{4'hF, 4'hD, 4'h9, 1'b0, 1'b1};
    vecs[12] = '{4'hF, 4'hB, 4'h9, 1'b0, 1'b0};
    vecs[13] = '{4'hE, 4'hB, 4'h9, 1'b0, 1'b0};
    vecs[14] = '{4'hE, 4'hB, 4'h9, 1'b0, 1'b0};
    vecs[15] = '{4'hF, 4'h7, 4'h9, 1'b0, 1'b0};
    vecs[16] = '{4'hF, 4'hE, 4'h9, 1'b0, 1'b0};
    vecs[17] = '{4'h5, 4'hE, 4'h9, 1'b0, 1'b0};
    vecs[18] = '{4'h5, 4'hE, 4'h9, 1'b0, 1'b0};
    vecs[19] = '{4'h5, 4'hE, 4'h9, 1'b0, 1'b0};
    vecs[20] = '{4'h5, 4'hE, 4'h4, 1'b1, 1'b1};
    vecs[21] = '{4'hD, 4'hE, 4'h4, 1'b0, 1'b1};
    vecs[22] = '{4'h5, 4'hE, 4'h4, 1'b0, 1'b1};
    vecs[23] = '{4'hF, 4'hE, 4'h4, 1'b0, 1'b1};
    vecs[24] = '{4'hF, 4'hE, 4'h4, 1'b0, 1'b1};
    vecs[25] = '{4'hD, 4'hE, 4'h4, 1'b0, 1'b1};
    vecs[26] = '{4'hD, 4'hE, 4'h4, 1'b0, 1'b1};
    vecs[27] = '{4'hF, 4'hE, 4'h4, 1'b0, 1'b1};
    vecs[28] = '{4'hF, 4'hE, 4'h4, 1'b0, 1'b1};
    vecs[29] = '{4'hF, 4'hD, 4'h4, 1'b0, 1'b0};
    vecs[30] = '{4'hF, 4'hB, 4'h4, 1'b0, 1'b0};

    Reset = 1'b0;
    row   = 4'hF;
    #12;
    chk("reset_col", col, 4'hE);
    chk("reset_key", key, 4'h0);
    chk("reset_valid", {3'b0, valid}, 4'h0);
    chk("reset_pressed", {3'b0, pressed}, 4'h0);

    // First tick lands DIV+1 clocks after reset release.
    @(negedge MHz); Reset = 1'b1;
    for (int unsigned e = 1; e <= 4; e++) begin
      @(posedge MHz); #1;
      chk("first_tick_col", col, (e < 4) ? 4'hE : 4'hD);
    end

    @(negedge MHz); Reset = 1'b0;
    #1 chk("rereset_col", col, 4'hE);
    @(negedge MHz); Reset = 1'b1;

    for (int unsigned i = 0; i < 31; i++) begin
      apply_tick(vecs[i].row);
      chk($sformatf("vec%0d_col", i), col, vecs[i].col);
      chk($sformatf("vec%0d_key", i), key, vecs[i].key);
      chk($sformatf("vec%0d_valid", i), {3'b0, valid}, {3'b0, vecs[i].valid});
      chk($sformatf("vec%0d_pressed", i), {3'b0, pressed}, {3'b0, vecs[i].pressed});
    end

    // Row 3 pressed on column 2 reaches HELD, then reset aborts it.
    for (int unsigned i = 0; i < 4; i++) apply_tick(4'h7);
    chk("held_key", key, 4'hE);
    chk("held_valid", {3'b0, valid}, 4'h1);
    chk("held_pressed", {3'b0, pressed}, 4'h1);
    chk("held_col", col, 4'hB);
    @(negedge MHz); Reset = 1'b0;
    #1;
    chk("abort_pressed", {3'b0, pressed}, 4'h0);
    chk("abort_col", col, 4'hE);
    chk("abort_key", key, 4'h0);
    repeat (2) begin
      @(negedge MHz);
      chk("abort_valid", {3'b0, valid}, 4'h0);
    end
    Reset = 1'b1;
    model_reset();

    // Key still held across reset: a fresh full debounce is required.
    for (int unsigned i = 0; i < 5; i++) begin
      apply_tick(4'h7);
      model_step(4'h7);
      model_check();
    end

    ticks = 0;
    while (ticks < 220) begin
      case ($urandom_range(0, 3))
        0, 1:    r = 4'hF;
        2:       r = ~(4'b0001 << $urandom_range(0, 3));
        default: r = 4'($urandom);
      endcase
      len = (r == 4'hF) ? $urandom_range(1, 5) : $urandom_range(1, 8);
      repeat (len) begin
        apply_tick(r);
        model_step(r);
        model_check();
        ticks++;
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/keypad_scan.md
KEYPAD_SCAN -- requirements
Module: keypad_scan

Interface
REQ-001 Parameter DIV, default 4999, sets the scan tick period; one tick every DIV+1 clocks.
REQ-002 Parameter DB_N, default 7, is the number of consecutive confirming ticks for press and release debounce.
REQ-003 Port MHz, input, 1 bit: system clock; all logic is on its rising edge.
REQ-004 Port Reset, input, 1 bit: asynchronous, active-low reset.
REQ-005 Port row, input, 4 bits: keypad row sense lines, active-low and externally pulled high.
REQ-006 Port col, output, 4 bits: keypad column drive, one-hot active-low.
REQ-007 Port key, output, 4 bits: code of the last accepted key, equal to row_index*4+col_index.
REQ-008 Port valid, output, 1 bit: one-clock pulse when a new key is accepted.
REQ-009 Port pressed, output, 1 bit: high while the accepted key is held.

Function
REQ-010 Row inputs shall pass through a 2-flop synchronizer; all row decisions shall use the synchronized value rs.
REQ-011 The tick counter shall run 0..DIV, wrap to 0, and assert tick for one clock when it equals DIV; it shall run in every state.
REQ-012 col shall equal ~(4'b0001 << col_idx), with col_idx a 2-bit index that wraps from 3 to 0.
REQ-013 The FSM shall have four states: SCAN, PDB (press debounce), HELD, RDB (release debounce); FSM activity occurs only on tick cycles.
REQ-014 SCAN, rs==4'hF on a tick: col_idx shall advance by 1.
REQ-015 SCAN, any rs bit low on a tick: capture r_idx as the lowest-numbered low bit, hold col_idx, set db_cnt=0, and go to PDB.
REQ-016 PDB, rs[r_idx]==0 on a tick: increment db_cnt; when db_cnt reaches DB_N, go to HELD.
REQ-017 On the PDB-to-HELD transition: key<={r_idx,col_idx}, valid=1 for exactly the next clock, pressed<=1.
REQ-018 PDB, rs[r_idx]==1 on a tick: return to SCAN, advance col_idx, leave key unchanged, and assert no valid.
REQ-019 HELD, rs[r_idx]==1 on a tick: set db_cnt=1 and go to RDB; otherwise stay in HELD.
REQ-020 RDB, rs[r_idx]==1 on a tick: increment db_cnt; when db_cnt reaches DB_N, set pressed<=0, advance col_idx, and go to SCAN.
REQ-021 RDB, rs[r_idx]==0 on a tick: return to HELD with pressed still 1.
REQ-022 col_idx shall stay frozen in PDB, HELD, and RDB.
REQ-023 Other keys pressed while in PDB, HELD, or RDB shall be ignored; only r_idx of the held column is monitored.
REQ-024 Multiple low rows in SCAN: the lowest row index wins.
REQ-025 key shall retain its value until the next accepted press.
REQ-026 db_cnt shall be wide enough for DB_N and shall saturate rather than wrap.

Reset
REQ-027 Reset low shall immediately set: state=SCAN, tick counter=0, col_idx=0, col=4'b1110, key=0, valid=0, pressed=0, db_cnt=0, synchronizer flops=4'hF.
REQ-028 Reset asserted mid-PDB, HELD, or RDB shall abort with no valid pulse; after release, scanning restarts at column 0.
REQ-029 After Reset goes high, the first tick shall occur DIV+1 clocks later.

Verification (DIV=3, DB_N=3)
REQ-030 Idle rows=4'hF: col sequence 1110, 1101, 1011, 0111, 1110, changing every 4 clocks; valid stays 0.
REQ-031 Row 2 held low while col_idx=1 for ≥4 ticks: exactly one valid pulse, key=4'h9, pressed=1, col frozen at 1101.
REQ-032 Release of that key for 3 ticks: pressed falls, col advances to 1011; release for only 2 ticks then re-press: pressed stays 1 and no new valid.
REQ-033 Row low for 2 ticks (bounce) then high: no valid, key unchanged, scanning resumes.
REQ-034 Rows 1 and 3 low together on column 0: key=4'h4 accepted; row 3 activity during HELD is ignored.
REQ-035 Reset pulsed during HELD: pressed=0 and col=1110 immediately; no valid until a fresh press completes debounce.
